bitbang_seq: RTL and testbench

//  Timed pattern sequencer for bitbang_ctrl. Software or an upstream FSM queues steps: direction, outval, hold, sample flag.

---
 rtl/bitbang_seq_pkg.sv | 14 +
 rtl/bitbang_seq_cmd_fifo.sv | 49 ++++
 rtl/bitbang_seq.sv | 171 +++++++++++++++++
 tb/tb_bitbang_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitbang_seq_pkg.sv
// Shared types and helpers for the bitbang step sequencer.
// A queued step is packed as {dir, outval, hold, sample}, sample in bit 0.
package bitbang_seq_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic int unsigned step_width(input int unsigned io_num, input int unsigned hold_w);
    return 2 * io_num + hold_w + 1;
  endfunction

endpackage

// File: rtl/bitbang_seq_cmd_fifo.sv
// Synchronous show-ahead FIFO for queued sequencer steps.
// rdata always presents the oldest entry; flush empties the queue in one cycle.
module bitbang_seq_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW + 1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bitbang_seq.sv
// Timed pattern sequencer feeding bitbang_ctrl: replays queued steps on the pins,
// each for max(hold,1) cycles, optionally capturing synchronized pin inputs.
module bitbang_seq
  import bitbang_seq_pkg::*;
#(
  parameter int unsigned IO_NUM_OF   = 10,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [IO_NUM_OF-1:0]     cmd_dir,
  input  logic [IO_NUM_OF-1:0]     cmd_outval,
  input  logic [HOLD_W-1:0]        cmd_hold,
  input  logic                     cmd_sample,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [IO_NUM_OF-1:0]     io_direction,
  output logic [IO_NUM_OF-1:0]     io_outval,
  input  logic [IO_NUM_OF-1:0]     io_inval,
  output logic                     smp_valid,
  output logic [IO_NUM_OF-1:0]     smp_data
);

  localparam int unsigned StepW = step_width(IO_NUM_OF, HOLD_W);

  logic [StepW-1:0]     fifo_wdata;
  logic [StepW-1:0]     fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  logic [IO_NUM_OF-1:0] step_dir;
  logic [IO_NUM_OF-1:0] step_out;
  logic [HOLD_W-1:0]    step_hold;
  logic                 step_sample;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    cnt_q, cnt_d;
  logic [IO_NUM_OF-1:0] dir_q, dir_d;
  logic [IO_NUM_OF-1:0] out_q, out_d;
  logic                 smp_flag_q, smp_flag_d;
  logic                 done_q, done_d;
  logic                 smp_valid_q, smp_valid_d;
  logic [IO_NUM_OF-1:0] smp_data_q, smp_data_d;
  logic [IO_NUM_OF-1:0] sync_q [SYNC_STAGES];

  assign cmd_ready  = !fifo_full && !abort;
  assign fifo_wdata = {cmd_dir, cmd_outval, cmd_hold, cmd_sample};

  assign step_sample = fifo_rdata[0];
  assign step_hold   = fifo_rdata[HOLD_W:1];
  assign step_out    = fifo_rdata[HOLD_W+IO_NUM_OF:HOLD_W+1];
  assign step_dir    = fifo_rdata[StepW-1:HOLD_W+IO_NUM_OF+1];

  bitbang_seq_cmd_fifo #(
    .WIDTH (StepW),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (cmd_valid && cmd_ready),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    out_d       = out_q;
    smp_flag_d  = smp_flag_q;
    smp_data_d  = smp_data_q;
    smp_valid_d = 1'b0;
    done_d      = 1'b0;
    fifo_pop    = 1'b0;

    if (abort) begin
      // Release pins but keep the last output value; any pending sample is dropped.
      state_d = StIdle;
      dir_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              state_d  = StRun;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (cnt_q == HOLD_W'(1)) begin
            if (smp_flag_q) begin
              smp_data_d  = sync_q[SYNC_STAGES-1];
              smp_valid_d = 1'b1;
            end
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      if (fifo_pop) begin
        cnt_d      = (step_hold == '0) ? HOLD_W'(1) : step_hold;
        dir_d      = step_dir;
        out_d      = step_out;
        smp_flag_d = step_sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      dir_q       <= '0;
      out_q       <= '0;
      smp_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      smp_flag_q  <= smp_flag_d;
      done_q      <= done_d;
      smp_valid_q <= smp_valid_d;
      smp_data_q  <= smp_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io_inval;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign busy         = (state_q == StRun);
  assign done         = done_q;
  assign io_direction = dir_q;
  assign io_outval    = out_q;
  assign smp_valid    = smp_valid_q;
  assign smp_data     = smp_data_q;

endmodule

// File: tb/tb_bitbang_seq.sv
// Directed bench for bitbang_seq; a pad model feeds io_inval from the driven pins
// and an external pad value on released pins.
module tb_bitbang_seq;

  localparam int unsigned IO    = 10;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned HW    = 16;
  localparam int unsigned SS    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [IO-1:0]           cmd_dir = '0;
  logic [IO-1:0]           cmd_outval = '0;
  logic [HW-1:0]           cmd_hold = '0;
  logic                    cmd_sample = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic                    busy;
  logic                    done;
  logic [$clog2(DEPTH):0]  level;
  logic [IO-1:0]           io_direction;
  logic [IO-1:0]           io_outval;
  logic [IO-1:0]           io_inval;
  logic                    smp_valid;
  logic [IO-1:0]           smp_data;
  logic [IO-1:0]           pad_ext = 10'h3A5;

  int checks = 0;
  int errors = 0;

  assign io_inval = (io_outval & io_direction) | (pad_ext & ~io_direction);

  always #5 clk = ~clk;

  bitbang_seq #(
    .IO_NUM_OF   (IO),
    .DEPTH       (DEPTH),
    .HOLD_W      (HW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_dir      (cmd_dir),
    .cmd_outval   (cmd_outval),
    .cmd_hold     (cmd_hold),
    .cmd_sample   (cmd_sample),
    .start        (start),
    .abort        (abort),
    .busy         (busy),
    .done         (done),
    .level        (level),
    .io_direction (io_direction),
    .io_outval    (io_outval),
    .io_inval     (io_inval),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [IO-1:0] d, input logic [IO-1:0] o, input logic [HW-1:0] h,
                      input logic s);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_outval = o;
    cmd_hold   = h;
    cmd_sample = s;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_dir", 32'(io_direction), 32'h0);
    check("rst_out", 32'(io_outval), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_smpv", 32'(smp_valid), 32'h0);
    check("rst_smpd", 32'(smp_data), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    rst = 1'b0;
    tick();

    // 1: two steps back to back, zero gap, done after last
    push(10'h3FF, 10'h2AA, 16'd3, 1'b0);
    push(10'h3FF, 10'h155, 16'd2, 1'b0);
    check("t1_level", 32'(level), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t1_out_a", 32'(io_outval), 32'h2AA);
      check("t1_busy_a", 32'(busy), 32'h1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      check("t1_out_b", 32'(io_outval), 32'h155);
      check("t1_done_b", 32'(done), 32'h0);
      tick();
    end
    check("t1_done", 32'(done), 32'h1);
    check("t1_busy_end", 32'(busy), 32'h0);
    check("t1_out_end", 32'(io_outval), 32'h155);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_out_keep", 32'(io_outval), 32'h155);
    check("t1_dir_keep", 32'(io_direction), 32'h3FF);

    // 2: released pins, pad drives 3A5, sample at end of a 4-cycle step
    push(10'h000, 10'h000, 16'd4, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_dir", 32'(io_direction), 32'h0);
      check("t2_smpv_lo", 32'(smp_valid), 32'h0);
      tick();
    end
    check("t2_smpv", 32'(smp_valid), 32'h1);
    check("t2_smpd", 32'(smp_data), 32'h3A5);
    check("t2_done", 32'(done), 32'h1);
    tick();
    check("t2_smpv_pulse", 32'(smp_valid), 32'h0);

    // 3: hold=0 acts as 1; sample sees pins from before the new drive
    pad_ext = 10'h0C3;
    tick();
    tick();
    push(10'h255, 10'h3FF, 16'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3_dir", 32'(io_direction), 32'h255);
    check("t3_busy", 32'(busy), 32'h1);
    check("t3_smpv_lo", 32'(smp_valid), 32'h0);
    tick();
    check("t3_busy_end", 32'(busy), 32'h0);
    check("t3_smpv", 32'(smp_valid), 32'h1);
    check("t3_smpd_old", 32'(smp_data), 32'h0C3);
    check("t3_done", 32'(done), 32'h1);

    // 4: fill the FIFO, 17th push refused, then push during RUN
    tick();
    for (int i = 0; i < 16; i++) begin
      cmd_valid  = 1'b1;
      cmd_dir    = 10'h3FF;
      cmd_outval = 10'(i);
      cmd_hold   = 16'd1;
      cmd_sample = 1'b0;
      tick();
    end
    check("t4_level_full", 32'(level), 32'd16);
    check("t4_ready_full", 32'(cmd_ready), 32'h0);
    cmd_outval = 10'h3C0;
    tick();
    cmd_valid = 1'b0;
    check("t4_level_refused", 32'(level), 32'd16);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_step0", 32'(io_outval), 32'h0);
    check("t4_ready_run", 32'(cmd_ready), 32'h1);
    push(10'h3FF, 10'h2C3, 16'd1, 1'b0);
    for (int i = 1; i < 17; i++) begin
      check("t4_step", 32'(io_outval), (i < 16) ? 32'(i) : 32'h2C3);
      check("t4_busy", 32'(busy), 32'h1);
      tick();
    end
    check("t4_done", 32'(done), 32'h1);
    check("t4_busy_end", 32'(busy), 32'h0);

    // 5: abort mid-step
    push(10'h3FF, 10'h0F0, 16'd100, 1'b1);
    push(10'h3FF, 10'h00F, 16'd5, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("t5_busy_pre", 32'(busy), 32'h1);
    check("t5_level_pre", 32'(level), 32'd1);
    check("t5_out_pre", 32'(io_outval), 32'h0F0);
    abort = 1'b1;
    #1;
    check("t5_ready_abort", 32'(cmd_ready), 32'h0);
    tick();
    abort = 1'b0;
    check("t5_dir", 32'(io_direction), 32'h0);
    check("t5_out", 32'(io_outval), 32'h0F0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_level", 32'(level), 32'h0);
    check("t5_done", 32'(done), 32'h0);
    check("t5_smpv", 32'(smp_valid), 32'h0);
    tick();
    check("t5_done_late", 32'(done), 32'h0);
    check("t5_busy_late", 32'(busy), 32'h0);

    // 6: start on empty FIFO, then reset during RUN
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_done", 32'(done), 32'h1);
    check("t6_busy", 32'(busy), 32'h0);
    tick();
    check("t6_done_pulse", 32'(done), 32'h0);
    push(10'h3FF, 10'h155, 16'd50, 1'b1);
    push(10'h3FF, 10'h2AA, 16'd5, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t6_busy_run", 32'(busy), 32'h1);
    check("t6_smpd_pre", 32'(smp_data), 32'h0C3);
    rst = 1'b1;
    tick();
    check("t6_rst_dir", 32'(io_direction), 32'h0);
    check("t6_rst_out", 32'(io_outval), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_level", 32'(level), 32'h0);
    check("t6_rst_smpd", 32'(smp_data), 32'h0);
    check("t6_rst_smpv", 32'(smp_valid), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    check("t6_rst_ready", 32'(cmd_ready), 32'h1);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
